// File: rtl/spi_arb_pkg.sv
// Shared types and pin idle levels for the SPI flash arbiter.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN   = 2'd1,
        ST_GUARD = 2'd2
    } arb_state_t;

    localparam logic CSN_IDLE  = 1'b1;
    localparam logic CLK_IDLE  = 1'b1;
    localparam logic MOSI_IDLE = 1'b0;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set req bit after last, with wrap-around.
module rr_pick #(
    parameter int N = 2,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] idx,
    output logic         valid
);

    always_comb begin
        idx   = '0;
        valid = |req;
        // Walk from the farthest candidate down so the nearest one wins.
        for (int i = N; i >= 1; i--) begin
            if (req[(int'(last) + i) % N]) begin
                idx = W'((int'(last) + i) % N);
            end
        end
    end

endmodule

// File: rtl/spi_flash_arbiter.sv
// Shares one SPI flash between several SPI masters, one whole
// transaction at a time, with a csn-high guard between owners.
module spi_flash_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int GUARD_CYCLES = 4,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               preempt,
    output logic               proto_err,
    input  logic [NUM_REQ-1:0] m_spi_clk,
    input  logic [NUM_REQ-1:0] m_spi_mosi,
    input  logic [NUM_REQ-1:0] m_spi_csn,
    output logic [NUM_REQ-1:0] m_spi_miso,
    output logic               spi_clk,
    output logic               spi_mosi,
    output logic               spi_csn,
    input  logic               spi_miso
);

    localparam int OW = $clog2(NUM_REQ);
    localparam int GW = $clog2(GUARD_CYCLES + 1);
    localparam int IW = $clog2(IDLE_TIMEOUT + 2);

    localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES - 1);
    localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_TIMEOUT - 1);

    arb_state_t         state_q, state_d;
    logic [OW-1:0]      own_q, own_d;
    logic [OW-1:0]      last_q, last_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [GW-1:0]      gcnt_q, gcnt_d;
    logic [IW-1:0]      icnt_q, icnt_d;
    logic               preempt_q, preempt_d;
    logic               perr_q, perr_d;

    logic [OW-1:0]      pick;
    logic               pick_valid;
    logic [NUM_REQ-1:0] own_mask;
    logic               others_waiting;

    rr_pick #(
        .N (NUM_REQ),
        .W (OW)
    ) u_pick (
        .req   (req),
        .last  (last_q),
        .idx   (pick),
        .valid (pick_valid)
    );

    assign own_mask       = NUM_REQ'(1) << own_q;
    assign others_waiting = |(req & ~own_mask);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            own_q     <= '0;
            last_q    <= OW'(NUM_REQ - 1);
            grant_q   <= '0;
            gcnt_q    <= '0;
            icnt_q    <= '0;
            preempt_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            own_q     <= own_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            gcnt_q    <= gcnt_d;
            icnt_q    <= icnt_d;
            preempt_q <= preempt_d;
            perr_q    <= perr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        own_d     = own_q;
        last_d    = last_q;
        grant_d   = grant_q;
        gcnt_d    = gcnt_q;
        icnt_d    = '0;
        preempt_d = 1'b0;
        perr_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    own_d   = pick;
                    grant_d = NUM_REQ'(1) << pick;
                    state_d = ST_OWN;
                end
            end
            ST_OWN: begin
                // A release wins over a timeout in the same cycle.
                if (!req[own_q]) begin
                    perr_d  = !m_spi_csn[own_q];
                    grant_d = '0;
                    last_d  = own_q;
                    gcnt_d  = GUARD_LOAD;
                    state_d = ST_GUARD;
                end else if (IDLE_TIMEOUT != 0 && m_spi_csn[own_q]
                             && others_waiting) begin
                    if (icnt_q == IDLE_LAST) begin
                        preempt_d = 1'b1;
                        grant_d   = '0;
                        last_d    = own_q;
                        gcnt_d    = GUARD_LOAD;
                        state_d   = ST_GUARD;
                    end else begin
                        icnt_d = icnt_q + IW'(1);
                    end
                end
            end
            ST_GUARD: begin
                if (gcnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gcnt_d = gcnt_q - GW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Pin mux is combinational so the owner sees no extra SPI latency.
    always_comb begin
        spi_csn    = CSN_IDLE;
        spi_clk    = CLK_IDLE;
        spi_mosi   = MOSI_IDLE;
        m_spi_miso = '0;
        if (state_q == ST_OWN) begin
            spi_csn           = m_spi_csn[own_q];
            spi_clk           = m_spi_clk[own_q];
            spi_mosi          = m_spi_mosi[own_q];
            m_spi_miso[own_q] = spi_miso;
        end
    end

    assign grant     = grant_q;
    assign preempt   = preempt_q;
    assign proto_err = perr_q;

endmodule
